// File: rtl/mux2_share_arbiter_pkg.sv
// mux2_share_arbiter_pkg
//   Shared types and constants for the two-source round-robin mux arbiter.
//   - state_t : output-stage FSM encoding (IDLE / HOLD_X / HOLD_Y)
//   - SRC_X / SRC_Y : source identifiers used for m_src, sel and priority
package mux2_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_X = 2'd1,
    HOLD_Y = 2'd2
  } state_t;

  localparam logic SRC_X = 1'b0;
  localparam logic SRC_Y = 1'b1;

endpackage

// File: rtl/mux2_share_arbiter_if.sv
// mux2_share_arbiter_if
//   Bundles the two producer handshakes (X, Y) and the consumer handshake (M).
//   Ports (all logic):
//     x_valid, x_data[WIDTH], x_ready  : producer X
//     y_valid, y_data[WIDTH], y_ready  : producer Y
//     m_valid, m_data[WIDTH], m_src, m_ready : consumer side
//   Modports:
//     slave  : the arbiter's view (takes producer data, drives the output stage)
//     master : the environment's view (producers + consumer)
//
// Handshake semantics (all three channels): a word moves on a rising clock
// edge where valid && ready are both high. The sender keeps valid and data
// stable until that edge; ready may rise or fall freely and never depends
// combinationally on the same channel's data.
interface mux2_share_arbiter_if #(
  parameter int WIDTH = 4
) ();

  logic             x_valid;
  logic [WIDTH-1:0] x_data;
  logic             x_ready;

  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_src;
  logic             m_ready;

  modport slave (
    input  x_valid, x_data, y_valid, y_data, m_ready,
    output x_ready, y_ready, m_valid, m_data, m_src
  );

  modport master (
    output x_valid, x_data, y_valid, y_data, m_ready,
    input  x_ready, y_ready, m_valid, m_data, m_src
  );

endinterface

// File: rtl/mux2_share_arbiter_mux2.sv
// mux2_share_arbiter_mux2
//   Single-bit 2:1 mux cell; replicated per data bit by the top.
//   Ports:
//     i_a   : input selected when i_sel = 0
//     i_b   : input selected when i_sel = 1
//     i_sel : select
//     o_y   : selected bit
module mux2_share_arbiter_mux2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux2_share_arbiter.sv
// mux2_share_arbiter
//   Shares one WIDTH-bit 2:1 mux between producers X and Y with round-robin
//   arbitration and a single-entry registered output stage. Per-source
//   transfer counters give simple bandwidth monitoring.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : interface (slave modport) with X/Y/M handshakes
//     sel       : current mux select (0 = X, 1 = Y), combinational
//     x_count   : accepted X words, modulo 2^CNT_W
//     y_count   : accepted Y words, modulo 2^CNT_W
//     dbg_state : output-stage FSM state for observation
module mux2_share_arbiter
  import mux2_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux2_share_arbiter_if.slave bus,
  output logic                sel,
  output logic [CNT_W-1:0]    x_count,
  output logic [CNT_W-1:0]    y_count,
  output state_t              dbg_state
);

  state_t           r_state;
  logic             r_m_valid;
  logic             r_m_src;
  logic [WIDTH-1:0] r_m_data;
  logic             r_prio;      // source that wins the next tie
  logic             r_sel;       // last granted source, held while idle
  logic [CNT_W-1:0] r_x_count;
  logic [CNT_W-1:0] r_y_count;

  logic             w_accept;
  logic             w_grant_x;
  logic             w_grant_y;
  logic             w_any_grant;
  logic             w_load;
  logic             w_sel;
  logic [WIDTH-1:0] w_mux;

  // The stage can load when empty or when its word leaves this same cycle,
  // which gives full throughput with no bubble.
  assign w_accept    = !r_m_valid || bus.m_ready;

  // Grants depend only on the valids and the priority register, never on data.
  assign w_grant_x   = bus.x_valid && (!bus.y_valid || (r_prio == SRC_X));
  assign w_grant_y   = bus.y_valid && (!bus.x_valid || (r_prio == SRC_Y));
  assign w_any_grant = w_grant_x || w_grant_y;
  assign w_load      = w_accept && w_any_grant;

  assign w_sel       = w_any_grant ? w_grant_y : r_sel;
  assign sel         = w_sel;

  assign bus.x_ready = w_accept && w_grant_x;
  assign bus.y_ready = w_accept && w_grant_y;

  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_src   = r_m_src;
  assign x_count     = r_x_count;
  assign y_count     = r_y_count;
  assign dbg_state   = r_state;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
    mux2_share_arbiter_mux2 u_mux2 (
      .i_a   (bus.x_data[gi]),
      .i_b   (bus.y_data[gi]),
      .i_sel (w_sel),
      .o_y   (w_mux[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_m_valid <= 1'b0;
      r_m_src   <= SRC_X;
      r_m_data  <= '0;
      r_prio    <= SRC_X;
      r_sel     <= SRC_X;
      r_x_count <= '0;
      r_y_count <= '0;
    end else begin
      if (w_any_grant) begin
        r_sel <= w_grant_y;
      end

      if (w_load) begin
        r_m_data  <= w_mux;
        r_m_valid <= 1'b1;
        r_m_src   <= w_grant_y ? SRC_Y : SRC_X;
        r_state   <= w_grant_y ? HOLD_Y : HOLD_X;
        // Loser of this transfer gets the next tie.
        r_prio    <= w_grant_y ? SRC_X : SRC_Y;
      end else if (r_m_valid && bus.m_ready) begin
        // m_src keeps its last value while idle; it is only meaningful with m_valid.
        r_m_valid <= 1'b0;
        r_state   <= IDLE;
      end

      if (bus.x_valid && bus.x_ready) begin
        r_x_count <= r_x_count + 1'b1;
      end
      if (bus.y_valid && bus.y_ready) begin
        r_y_count <= r_y_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux2_share_arbiter.sv
module tb_mux2_share_arbiter;
  import mux2_share_arbiter_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic               clk;
  logic               rst_n;
  logic               sel;
  logic [CNT_W-1:0]   x_count;
  logic [CNT_W-1:0]   y_count;
  state_t             dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mux2_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux2_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sel       (sel),
    .x_count   (x_count),
    .y_count   (y_count),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic xv, input logic [3:0] xd,
                       input logic yv, input logic [3:0] yd, input logic mr);
    bus.x_valid = xv;
    bus.x_data  = xd;
    bus.y_valid = yv;
    bus.y_data  = yd;
    bus.m_ready = mr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard primitives
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic xr, input logic yr, input logic s);
    @(negedge clk);
    chk({tag, ".x_ready"}, 32'(bus.x_ready), 32'(xr));
    chk({tag, ".y_ready"}, 32'(bus.y_ready), 32'(yr));
    chk({tag, ".sel"},     32'(sel),         32'(s));
  endtask

  task automatic chk_out(input string tag, input logic mv, input logic [3:0] md,
                         input logic ms, input logic [1:0] xc, input logic [1:0] yc);
    next_cycle();
    chk({tag, ".m_valid"}, 32'(bus.m_valid), 32'(mv));
    chk({tag, ".m_data"},  32'(bus.m_data),  32'(md));
    chk({tag, ".m_src"},   32'(bus.m_src),   32'(ms));
    chk({tag, ".x_count"}, 32'(x_count),     32'(xc));
    chk({tag, ".y_count"}, 32'(y_count),     32'(yc));
  endtask

  logic [3:0] wrap_data [4] = '{4'h1, 4'h4, 4'h8, 4'hF};
  logic [1:0] wrap_cnt  [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    rst_n = 1'b0;
    drive(0, 4'h0, 0, 4'h0, 0);
    #2;
    chk("rst.m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst.m_data",  32'(bus.m_data),  32'd0);
    chk("rst.m_src",   32'(bus.m_src),   32'd0);
    chk("rst.x_count", 32'(x_count),     32'd0);
    chk("rst.y_count", 32'(y_count),     32'd0);
    chk("rst.sel",     32'(sel),         32'd0);
    chk("rst.state",   32'(dbg_state),   32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Single X source
    drive(1, 4'b0010, 0, 4'h0, 1);
    chk_ready("x_only", 1, 0, 0);
    chk_out("x_only", 1, 4'b0010, 0, 2'd1, 2'd0);
    chk("x_only.state", 32'(dbg_state), 32'(HOLD_X));

    // Drain with nothing pending returns to IDLE; sel keeps last grant (X)
    drive(0, 4'h0, 0, 4'h0, 1);
    chk_ready("drain", 0, 0, 0);
    next_cycle();
    chk("drain.m_valid", 32'(bus.m_valid), 32'd0);
    chk("drain.state",   32'(dbg_state),   32'(IDLE));

    // Single Y source; afterwards X has priority
    drive(0, 4'h0, 1, 4'h5, 1);
    chk_ready("y_only", 0, 1, 1);
    chk_out("y_only", 1, 4'h5, 1, 2'd1, 2'd1);

    // Fair tie, continuous drain
    drive(1, 4'b0111, 1, 4'b1011, 1);
    chk_ready("tie0", 1, 0, 0);
    chk_out("tie0", 1, 4'b0111, 0, 2'd2, 2'd1);
    chk_ready("tie1", 0, 1, 1);
    chk_out("tie1", 1, 4'b1011, 1, 2'd2, 2'd2);
    chk_ready("tie2", 1, 0, 0);
    chk_out("tie2", 1, 4'b0111, 0, 2'd3, 2'd2);
    chk_ready("tie3", 0, 1, 1);
    chk_out("tie3", 1, 4'b1011, 1, 2'd3, 2'd3);

    // Backpressure for 3 cycles: everything frozen
    drive(1, 4'b0111, 1, 4'b1011, 0);
    for (int i = 0; i < 3; i++) begin
      chk_ready("bp", 0, 0, 0);
      chk_out("bp", 1, 4'b1011, 1, 2'd3, 2'd3);
    end

    // Release: alternation resumes with X (counts wrap in 2 bits)
    drive(1, 4'b0111, 1, 4'b1011, 1);
    chk_ready("rel0", 1, 0, 0);
    chk_out("rel0", 1, 4'b0111, 0, 2'd0, 2'd3);
    chk_ready("rel1", 0, 1, 1);
    chk_out("rel1", 1, 4'b1011, 1, 2'd0, 2'd0);

    // Back-to-back HOLD_X -> HOLD_Y with no bubble
    drive(1, 4'h3, 0, 4'h0, 1);
    chk_ready("b2b_x", 1, 0, 0);
    chk_out("b2b_x", 1, 4'h3, 0, 2'd1, 2'd0);
    drive(0, 4'h0, 1, 4'hC, 1);
    chk_ready("b2b_y", 0, 1, 1);
    chk_out("b2b_y", 1, 4'hC, 1, 2'd1, 2'd1);
    chk("b2b_y.state", 32'(dbg_state), 32'(HOLD_Y));

    // No request, no drain: hold word, sel holds Y
    drive(0, 4'h0, 0, 4'h0, 0);
    chk_ready("hold", 0, 0, 1);
    chk_out("hold", 1, 4'hC, 1, 2'd1, 2'd1);

    // Reset mid-operation with a word held and both sources valid
    drive(1, 4'h9, 1, 4'h6, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.m_valid", 32'(bus.m_valid), 32'd0);
    chk("mrst.m_data",  32'(bus.m_data),  32'd0);
    chk("mrst.x_count", 32'(x_count),     32'd0);
    chk("mrst.y_count", 32'(y_count),     32'd0);
    chk("mrst.sel",     32'(sel),         32'd0);
    chk("mrst.state",   32'(dbg_state),   32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    chk("mrst_tie.x_ready", 32'(bus.x_ready), 32'd1);
    chk("mrst_tie.y_ready", 32'(bus.y_ready), 32'd0);
    chk_out("mrst_tie", 1, 4'h9, 0, 2'd1, 2'd0);

    // Four more X transfers: x_count 2, 3, 0, 1
    for (int i = 0; i < 4; i++) begin
      drive(1, wrap_data[i], 0, 4'h0, 1);
      chk_ready("wrap", 1, 0, 0);
      chk_out("wrap", 1, wrap_data[i], 0, wrap_cnt[i], 2'd0);
    end

    drive(0, 4'h0, 0, 4'h0, 1);
    next_cycle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_share_arbiter.md
Name: mux2_share_arbiter

Overview:
- Shares one WIDTH-bit 2:1 mux datapath between two requesters, X and Y, using round-robin arbitration.
- Each requester presents data with a valid/ready handshake. The block drives the mux select and registers the selected word into a single-entry output stage with its own valid/ready handshake.
- Per-source transfer counters provide simple bandwidth monitoring.
- Sits between two producers and one downstream consumer on a shared bus.

Parameters:
- WIDTH, 4: data width of each source and of the output.
- CNT_W, 8: width of each per-source transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- x_valid  input  1  source X holds a word.
- x_data  input  WIDTH  source X word.
- x_ready  output  1  X word accepted this cycle.
- y_valid  input  1  source Y holds a word.
- y_data  input  WIDTH  source Y word.
- y_ready  output  1  Y word accepted this cycle.
- m_valid  output  1  output register holds a word.
- m_data  output  WIDTH  output word.
- m_src  output  1  source of the held word (0 = X, 1 = Y).
- m_ready  input  1  consumer takes the word this cycle.
- sel  output  1  current mux select (0 = X, 1 = Y); combinational.
- x_count  output  CNT_W  number of X words accepted, modulo 2^CNT_W.
- y_count  output  CNT_W  number of Y words accepted, modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - m_valid = 0, m_data = 0, m_src = 0.
  - x_count = 0, y_count = 0.
  - FSM = IDLE.
  - prio = X, meaning X wins the first tie.
- Accept condition: accept = !m_valid || m_ready. The output stage can load when it is empty or is being drained in the same cycle.
- Grant (combinational):
  - Only x_valid: grant X.
  - Only y_valid: grant Y.
  - Both valid: grant the source indicated by prio.
  - Neither valid: no grant.
- Handshake outputs:
  - x_ready = accept && grant_X.
  - y_ready = accept && grant_Y.
  - At most one ready is high in any cycle.
  - ready never depends combinationally on the same source's data.
- sel = grant_Y when a grant exists; otherwise sel holds its last granted value. sel reset value = 0.
- Datapath: m_data <= sel ? y_data : x_data on any accepted transfer. Latency is 1 cycle from input handshake to m_valid. Throughput is 1 word per cycle.
- prio update: on every accepted transfer, prio <= opposite of the granted source. prio does not change without a transfer.
- FSM states:
  - IDLE: m_valid = 0.
  - HOLD_X: holding an X word, m_src = 0.
  - HOLD_Y: holding a Y word, m_src = 1.
- FSM transitions, evaluated each cycle:
  - If accept and a grant exists: go to HOLD_X or HOLD_Y per grant. This includes back-to-back HOLD_X→HOLD_Y when m_ready is high.
  - Else if m_valid && m_ready: go to IDLE.
  - Else: stay.
- Backpressure: while m_valid && !m_ready:
  - m_data, m_src and m_valid are held stable.
  - x_ready = y_ready = 0.
- Source rule: a source keeps valid and data stable until its ready is high. The block does not check this rule.
- Counters:
  - x_count increments on x_valid && x_ready; y_count increments on y_valid && y_ready.
  - They wrap from 2^CNT_W−1 to 0 with no flag.
- Simultaneous events:
  - A drain and a load in the same cycle produce no bubble: m_valid stays 1 and data is replaced.
  - A request arriving in the same cycle as a drain is granted that cycle.
- Reset mid-operation: a held word is discarded, m_valid drops immediately (asynchronous), counters clear, prio returns to X.

Decomposition:
- Shared package:
  - State encoding constants IDLE = 2'd0, HOLD_X = 2'd1, HOLD_Y = 2'd2.
  - Source ID constants SRC_X = 1'b0, SRC_Y = 1'b1.
- Sub-module: the team's existing mux2 bit cell instanced WIDTH times in a generate loop as the datapath. Arbitration, FSM and counters stay in the top module.

Test Plan:
- Reset: assert rst_n = 0 mid-transfer with m_valid = 1 → m_valid = 0, counts = 0, sel = 0 immediately. First tie after release grants X.
- Single source: x_valid = 1, x_data = 4'b0010, m_ready = 1, y_valid = 0 → x_ready = 1 in cycle 0. Next cycle m_valid = 1, m_data = 4'b0010, m_src = 0, x_count = 1.
- Fair tie: x_data = 4'b0111 and y_data = 4'b1011 both valid continuously, m_ready = 1 → outputs alternate 0111, 1011, 0111, 1011 with m_src 0, 1, 0, 1. After 4 cycles x_count = y_count = 2.
- Backpressure: hold m_ready = 0 for 3 cycles with both sources valid → m_data stable, both ready = 0, counts unchanged. Releasing m_ready resumes alternation with no lost or duplicated word.
- Back-to-back drain and load: m_valid = 1, m_ready = 1, y_valid = 1 → y_ready = 1 that cycle and m_valid stays 1 next cycle with Y data (no bubble).
- Wrap: with CNT_W = 2, perform 5 X transfers → x_count sequence 1, 2, 3, 0, 1.
